// File: rtl/mem_array_ctrl.sv
// Main memory and LC-3 keyboard/display device registers behind the MAR/MDR stage.
// A multi-cycle access is held until a one-cycle R strobe reports completion.
module mem_array_ctrl #(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic [15:0] inData,
  input  logic        MIOEN,
  input  logic        RW,
  output logic        R,
  output logic [15:0] outData,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] COUNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  localparam logic [15:0] KBSR_ADDR = 16'hFE00;
  localparam logic [15:0] KBDR_ADDR = 16'hFE02;
  localparam logic [15:0] DSR_ADDR  = 16'hFE04;
  localparam logic [15:0] DDR_ADDR  = 16'hFE06;

  logic [1:0]  state;
  logic [3:0]  count;
  logic [15:0] reqAddr;
  logic [15:0] reqData;
  logic        reqWrite;

  logic [15:0] mem [2**ADDR_BITS];

  logic        kbsrFlag;
  logic [7:0]  kbdr;
  logic        dsrFlag;

  logic [15:0] curAddr;
  logic [15:0] curData;
  logic        curWrite;
  logic        isDevice;
  logic        enterDone;
  logic [15:0] readValue;

  // In IDLE the live request is used so device accesses can complete on the sampling edge.
  always_comb begin
    curAddr   = (state == IDLE) ? addr   : reqAddr;
    curData   = (state == IDLE) ? inData : reqData;
    curWrite  = (state == IDLE) ? RW     : reqWrite;
    isDevice  = (curAddr >= KBSR_ADDR);
    enterDone = 1'b0;
    if (state == IDLE) begin
      enterDone = MIOEN && (isDevice || (LATENCY == 1));
    end else if (state == BUSY) begin
      enterDone = MIOEN && (count == 4'd0);
    end
  end

  always_comb begin
    readValue = 16'h0000;
    if (!isDevice) begin
      readValue = mem[curAddr[ADDR_BITS-1:0]];
    end else begin
      case (curAddr)
        KBSR_ADDR: readValue = {kbsrFlag, 15'b0};
        KBDR_ADDR: readValue = {8'b0, kbdr};
        DSR_ADDR:  readValue = {dsrFlag, 15'b0};
        DDR_ADDR:  readValue = {8'b0, disp_data};
        default:   readValue = 16'h0000;
      endcase
    end
  end

  assign R = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= 4'd0;
      reqAddr  <= 16'h0000;
      reqData  <= 16'h0000;
      reqWrite <= 1'b0;
      outData  <= 16'h0000;
    end else begin
      if (enterDone && !curWrite) begin
        outData <= readValue;
      end
      case (state)
        IDLE: begin
          if (MIOEN) begin
            reqAddr  <= addr;
            reqData  <= inData;
            reqWrite <= RW;
            if (isDevice || (LATENCY == 1)) begin
              state <= DONE;
            end else begin
              count <= COUNT_LOAD;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!MIOEN) begin
            state <= IDLE;
          end else if (count == 4'd0) begin
            state <= DONE;
          end else begin
            count <= count - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is deliberately not reset; rst_n gating keeps an interrupted write from landing.
  always_ff @(posedge clk) begin
    if (rst_n && enterDone && curWrite && !isDevice) begin
      mem[curAddr[ADDR_BITS-1:0]] <= curData;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbsrFlag   <= 1'b0;
      kbdr       <= 8'h00;
      dsrFlag    <= 1'b1;
      disp_valid <= 1'b0;
      disp_data  <= 8'h00;
    end else begin
      if (enterDone && !curWrite && (curAddr == KBDR_ADDR)) begin
        kbsrFlag <= 1'b0;
      end
      if (kb_valid) begin
        kbdr     <= kb_data;
        kbsrFlag <= 1'b1;
      end
      if (disp_valid && disp_ready) begin
        disp_valid <= 1'b0;
        dsrFlag    <= 1'b1;
      end
      // A DDR write only lands while the display is idle, so it never races the handshake.
      if (enterDone && curWrite && (curAddr == DDR_ADDR) && dsrFlag) begin
        disp_data  <= curData[7:0];
        disp_valid <= 1'b1;
        dsrFlag    <= 1'b0;
      end
    end
  end

endmodule
